// File: rtl/i3c_pkg.sv
// Shared types and constants for the I3C bus monitor.
package i3c_pkg;

    typedef enum logic [1:0] {
        MonIdle        = 2'd0,
        MonActive      = 2'd1,
        MonBusFreeWait = 2'd2
    } i3c_mon_state_e;

    localparam int unsigned I3cFrameBits = 9;

endpackage

// File: rtl/i3c_mon_sync.sv
// SyncStages-deep two-bit synchroniser for the SCL/SDA lines; flops reset to
// the bus-idle level so a reset never looks like a bus condition.
module i3c_mon_sync #(
    parameter int SyncStages = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] d_i,
    output logic [1:0] q_o
);

    logic [SyncStages-1:0][1:0] stage_r;

    // Shift the raw line levels through the synchroniser chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_r <= {SyncStages{2'b11}};
        end else begin
            stage_r <= {stage_r[SyncStages-2:0], d_i};
        end
    end

    assign q_o = stage_r[SyncStages-1];

endmodule

// File: rtl/i3c_bus_monitor.sv
// Passive I3C bus observer: detects START/RSTART/STOP and decodes 9-bit frames.
// Optional bus-free idle timer: define I3C_BUS_MONITOR_IDLE_TIMER_EN.
module i3c_bus_monitor
    import i3c_pkg::*;
#(
    parameter int SyncStages = 2,
    parameter int IdleCycles = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       start_det_o,
    output logic       rstart_det_o,
    output logic       stop_det_o,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       ninth_bit_o,
    output logic       byte_is_addr_o,
    output logic       frame_err_o,
    output logic       bus_active_o
);

    logic [1:0]              sync_s;
    logic                    s_scl_s;
    logic                    s_sda_s;
    logic                    p_scl_r;
    logic                    p_sda_r;
    logic                    scl_rise_s;
    logic                    scl_high_s;
    logic                    start_s;
    logic                    stop_s;
    logic [3:0]              cnt_next_s;
    i3c_mon_state_e          state_r;
    logic [3:0]              bit_cnt_r;
    logic [I3cFrameBits-2:0] sr_r;
    logic                    addr_flag_r;

`ifdef I3C_BUS_MONITOR_IDLE_TIMER_EN
    localparam int IdleW = $clog2(IdleCycles + 1);
    logic [IdleW-1:0] idle_cnt_r;
    logic [IdleW-1:0] idle_cnt_next_s;
    assign idle_cnt_next_s = idle_cnt_r + IdleW'(1);
`endif

    i3c_mon_sync #(.SyncStages(SyncStages)) u_sync (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    ({scl_i, sda_i}),
        .q_o    (sync_s)
    );

    assign s_scl_s    = sync_s[1];
    assign s_sda_s    = sync_s[0];
    assign scl_rise_s = !p_scl_r & s_scl_s;
    // Requiring SCL high on both samples rejects simultaneous SCL/SDA changes.
    assign scl_high_s = p_scl_r & s_scl_s;
    assign start_s    = scl_high_s & p_sda_r & !s_sda_s;
    assign stop_s     = scl_high_s & !p_sda_r & s_sda_s;
    assign cnt_next_s = bit_cnt_r + 4'd1;

    // Condition detection, frame capture and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_scl_r        <= 1'b1;
            p_sda_r        <= 1'b1;
            state_r        <= MonIdle;
            bit_cnt_r      <= 4'd0;
            sr_r           <= {(I3cFrameBits-1){1'b0}};
            addr_flag_r    <= 1'b0;
            start_det_o    <= 1'b0;
            rstart_det_o   <= 1'b0;
            stop_det_o     <= 1'b0;
            byte_valid_o   <= 1'b0;
            byte_o         <= 8'd0;
            ninth_bit_o    <= 1'b0;
            byte_is_addr_o <= 1'b0;
            frame_err_o    <= 1'b0;
            bus_active_o   <= 1'b0;
`ifdef I3C_BUS_MONITOR_IDLE_TIMER_EN
            idle_cnt_r     <= IdleW'(0);
`endif
        end else begin
            p_scl_r      <= s_scl_s;
            p_sda_r      <= s_sda_s;
            start_det_o  <= 1'b0;
            rstart_det_o <= 1'b0;
            stop_det_o   <= 1'b0;
            byte_valid_o <= 1'b0;
            frame_err_o  <= 1'b0;
            case (state_r)
                MonIdle: begin
                    if (start_s) begin
                        state_r      <= MonActive;
                        start_det_o  <= 1'b1;
                        bit_cnt_r    <= 4'd0;
                        addr_flag_r  <= 1'b1;
                        bus_active_o <= 1'b1;
                    end else if (stop_s) begin
                        stop_det_o <= 1'b1;
                    end else begin
                        state_r <= MonIdle;
                    end
                end
                MonActive: begin
                    if (start_s) begin
                        rstart_det_o <= 1'b1;
                        frame_err_o  <= (bit_cnt_r != 4'd0);
                        bit_cnt_r    <= 4'd0;
                        addr_flag_r  <= 1'b1;
                    end else if (stop_s) begin
                        stop_det_o  <= 1'b1;
                        frame_err_o <= (bit_cnt_r != 4'd0);
                        bit_cnt_r   <= 4'd0;
`ifdef I3C_BUS_MONITOR_IDLE_TIMER_EN
                        state_r     <= MonBusFreeWait;
                        idle_cnt_r  <= IdleW'(0);
`else
                        state_r      <= MonIdle;
                        bus_active_o <= 1'b0;
`endif
                    end else if (scl_rise_s) begin
                        sr_r <= {sr_r[I3cFrameBits-3:0], s_sda_s};
                        // sr_r holds bits 1..8 when the ninth bit arrives.
                        if (cnt_next_s == 4'(I3cFrameBits)) begin
                            byte_o         <= sr_r;
                            ninth_bit_o    <= s_sda_s;
                            byte_is_addr_o <= addr_flag_r;
                            addr_flag_r    <= 1'b0;
                            byte_valid_o   <= 1'b1;
                            bit_cnt_r      <= 4'd0;
                        end else begin
                            bit_cnt_r <= cnt_next_s;
                        end
                    end else begin
                        state_r <= MonActive;
                    end
                end
`ifdef I3C_BUS_MONITOR_IDLE_TIMER_EN
                MonBusFreeWait: begin
                    if (start_s) begin
                        state_r      <= MonActive;
                        rstart_det_o <= 1'b1;
                        bit_cnt_r    <= 4'd0;
                        addr_flag_r  <= 1'b1;
                        idle_cnt_r   <= IdleW'(0);
                    end else if (stop_s) begin
                        stop_det_o <= 1'b1;
                        idle_cnt_r <= IdleW'(0);
                    end else if (s_scl_s & s_sda_s) begin
                        if (idle_cnt_next_s == IdleW'(IdleCycles)) begin
                            state_r      <= MonIdle;
                            bus_active_o <= 1'b0;
                            idle_cnt_r   <= IdleW'(0);
                        end else begin
                            idle_cnt_r <= idle_cnt_next_s;
                        end
                    end else begin
                        idle_cnt_r <= IdleW'(0);
                    end
                end
`endif
                default: begin
                    state_r      <= MonIdle;
                    bit_cnt_r    <= 4'd0;
                    bus_active_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i3c_bus_monitor.sv
// Scoreboard bench for i3c_bus_monitor: expected events are queued as the bus
// is driven and matched against every output pulse, including its latency.
module tb_i3c_bus_monitor;

    localparam int SS = 2;
    localparam int PH = 4;
    localparam logic [4:0] EV_START  = 5'b10000;
    localparam logic [4:0] EV_RSTART = 5'b01000;
    localparam logic [4:0] EV_STOP   = 5'b00100;
    localparam logic [4:0] EV_BYTE   = 5'b00010;
    localparam logic [4:0] EV_ERR    = 5'b00001;
`ifdef I3C_BUS_MONITOR_IDLE_TIMER_EN
    localparam logic STOP_ACT = 1'b1;
`else
    localparam logic STOP_ACT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       scl_i = 1'b1;
    logic       sda_i = 1'b1;
    logic       start_det_o, rstart_det_o, stop_det_o, byte_valid_o;
    logic [7:0] byte_o;
    logic       ninth_bit_o, byte_is_addr_o, frame_err_o, bus_active_o;

    typedef struct {
        logic [4:0]  pulses;
        logic [7:0]  byte_v;
        logic        ninth;
        logic        addr;
        logic        act;
        int unsigned at;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         mon_e;
    logic [4:0]  mon_pv;
    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    i3c_bus_monitor #(.SyncStages(SS), .IdleCycles(16)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .scl_i          (scl_i),
        .sda_i          (sda_i),
        .start_det_o    (start_det_o),
        .rstart_det_o   (rstart_det_o),
        .stop_det_o     (stop_det_o),
        .byte_valid_o   (byte_valid_o),
        .byte_o         (byte_o),
        .ninth_bit_o    (ninth_bit_o),
        .byte_is_addr_o (byte_is_addr_o),
        .frame_err_o    (frame_err_o),
        .bus_active_o   (bus_active_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic push(input logic [4:0] p, input logic [7:0] b, input logic n,
                        input logic a, input logic act);
        ev_t e;
        e.pulses = p; e.byte_v = b; e.ninth = n; e.addr = a; e.act = act;
        e.at = cyc + SS + 1;
        exp_q.push_back(e);
    endtask

    task automatic step(input logic scl, input logic sda);
        repeat (PH) @(posedge clk);
        #2;
        scl_i = scl;
        sda_i = sda;
    endtask

    task automatic send_bit(input logic b);
        step(1'b0, sda_i);
        step(1'b0, b);
        step(1'b1, b);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic n, input logic a);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        send_bit(n);
        push(EV_BYTE, b, n, a, 1'b1);
    endtask

    task automatic do_start(input logic [4:0] p);
        step(1'b1, 1'b0);
        push(p, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_stop(input logic [4:0] p);
        step(1'b1, 1'b1);
        push(p, 8'h00, 1'b0, 1'b0, STOP_ACT);
    endtask

    task automatic drain(input string tag);
        repeat (SS + PH + 4) @(posedge clk);
        chk({tag, "_drain"}, exp_q.size(), 0);
    endtask

    // Match every observed pulse cycle against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_ni) begin
            mon_pv = {start_det_o, rstart_det_o, stop_det_o, byte_valid_o, frame_err_o};
            if (mon_pv != 5'b00000) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", mon_pv, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pulses", mon_pv, mon_e.pulses);
                    chk("latency", cyc, mon_e.at);
                    chk("bus_active", bus_active_o, mon_e.act);
                    if (mon_e.pulses[1]) begin
                        chk("byte", byte_o, mon_e.byte_v);
                        chk("ninth", ninth_bit_o, mon_e.ninth);
                        chk("is_addr", byte_is_addr_o, mon_e.addr);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pulses", {start_det_o, rstart_det_o, stop_det_o, byte_valid_o, frame_err_o}, 0);
        chk("rst_byte", {byte_o, ninth_bit_o, byte_is_addr_o, bus_active_o}, 0);
        @(posedge clk);
        #2;
        rst_ni = 1'b1;
        repeat (5) @(posedge clk);

        // Single address frame 0xFC with ACK.
        do_start(EV_START);
        send_frame(8'hFC, 1'b0, 1'b1);
        #1;
        chk("t1_active_mid", bus_active_o, 1);
        do_stop(EV_STOP);
        drain("t1");
        chk("t1_byte_held", byte_o, 8'hFC);
        repeat (30) @(posedge clk);

        // Write, repeated START, read-style sequence.
        do_start(EV_START);
        send_frame(8'hA0, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b1, 1'b0);
        do_start(EV_RSTART);
        send_frame(8'hA1, 1'b0, 1'b1);
        send_frame(8'h3C, 1'b0, 1'b0);
        do_stop(EV_STOP);
        drain("t2");
        repeat (30) @(posedge clk);

        // Partial frame of four bits terminated by STOP.
        do_start(EV_START);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        do_stop(EV_STOP | EV_ERR);
        drain("t3");
        repeat (30) @(posedge clk);

        // Simultaneous edges and idle SCL pulses: nothing may be reported.
        step(1'b0, 1'b0);
        step(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1);
            step(1'b1, 1'b1);
        end
        drain("t4");
        chk("t4_idle", bus_active_o, 0);
        chk("t4_byte_held", byte_o, 8'h3C);

        // Reset after five bits of a frame.
        do_start(EV_START);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        chk("t5_pre_rst_q", exp_q.size(), 0);
        @(posedge clk);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t5_rst_pulses", {start_det_o, rstart_det_o, stop_det_o, byte_valid_o, frame_err_o}, 0);
        chk("t5_rst_state", {byte_o, ninth_bit_o, byte_is_addr_o, bus_active_o}, 0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        @(posedge clk);
        #2;
        rst_ni = 1'b1;
        repeat (5) @(posedge clk);
        chk("t5_post_rst_active", bus_active_o, 0);
        do_start(EV_START);
        send_frame(8'h55, 1'b0, 1'b1);
        do_stop(EV_STOP);
        drain("t5");
        repeat (30) @(posedge clk);

        // START shortly after STOP, then again after a long idle gap.
        do_start(EV_START);
        send_frame(8'h42, 1'b0, 1'b1);
        do_stop(EV_STOP);
        repeat (10 - PH) @(posedge clk);
`ifdef I3C_BUS_MONITOR_IDLE_TIMER_EN
        do_start(EV_RSTART);
`else
        do_start(EV_START);
`endif
        send_frame(8'h81, 1'b0, 1'b1);
        do_stop(EV_STOP);
        repeat (20 - PH) @(posedge clk);
        do_start(EV_START);
        send_frame(8'hD2, 1'b0, 1'b1);
        do_stop(EV_STOP);
        drain("t6");

        repeat (20) @(posedge clk);
        chk("final_q", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
